// File: rtl/sig_capture_unit_if.sv
// Bus-snoop and signature-stream signals of sig_capture_unit.
// master = bus/consumer side (testbench or SoC glue), slave = the capture unit.
interface sig_capture_unit_if;
   logic [31:0] bus_addr_i;
   logic [31:0] bus_wdata_i;
   logic        bus_wr_i;
   logic        sig_valid_o;
   logic [31:0] sig_data_o;
   logic        sig_ready_i;

   modport master (
      output bus_addr_i, bus_wdata_i, bus_wr_i, sig_ready_i,
      input  sig_valid_o, sig_data_o
   );

   modport slave (
      input  bus_addr_i, bus_wdata_i, bus_wr_i, sig_ready_i,
      output sig_valid_o, sig_data_o
   );
endinterface

// File: rtl/sig_capture_unit.sv
// End-of-test signature capture: snoops bus writes into a FWFT FIFO, drains over valid/ready.
// Optional running CRC-32 of accepted words when SIG_CAPTURE_CRC_EN is defined.
module sig_capture_unit #(
   parameter logic [31:0] SIG_ADDR       = 32'h8E000000,
   parameter logic [31:0] HALT_ADDR      = 32'h8F000000,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   sig_capture_unit_if.slave    bus,
   output logic [15:0]          sig_count_o,
   output logic                 halt_o,
   output logic                 done_o,
   output logic                 overflow_o,
   output logic                 timeout_o,
   output logic [31:0]          crc_o
);

   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam bit          WD_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES);
   localparam logic [31:0] WD_LAST  = WD_LIMIT - 32'd1;
   localparam logic [AW:0] OCC_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE, ST_TIMEOUT} state_e;

   state_e          state_q, state_d;
   logic [31:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     occ_q, occ_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [31:0]     cyc_q, cyc_d;
   logic            halt_q, halt_d;
   logic            done_q, done_d;
   logic            ovf_q, ovf_d;
   logic            to_q, to_d;

   logic empty, full, pop, push, drop, sig_hit, halt_hit, wd_hit, counting;

   always_comb begin
      empty    = (occ_q == '0);
      full     = (occ_q == OCC_FULL);
      pop      = !empty && bus.sig_ready_i;
      sig_hit  = bus.bus_wr_i && (bus.bus_addr_i == SIG_ADDR)  && (state_q == ST_RUN);
      halt_hit = bus.bus_wr_i && (bus.bus_addr_i == HALT_ADDR) && (state_q == ST_RUN);
      // a same-cycle pop frees the slot, so a full FIFO can still take the word
      push     = sig_hit && (!full || pop);
      drop     = sig_hit && full && !pop;
      counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      wd_hit   = WD_EN && counting && (cyc_q == WD_LAST);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (halt_hit)    state_d = ST_DRAIN;
            else if (wd_hit) state_d = ST_TIMEOUT;
         end
         ST_DRAIN: begin
            if (empty)       state_d = ST_DONE;
            else if (wd_hit) state_d = ST_TIMEOUT;
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      occ_d    = occ_q + (AW+1)'(push) - (AW+1)'(pop);
      cnt_d    = (push && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
      // counter parks at the limit so a halt that wins the race never re-fires it
      cyc_d    = (WD_EN && counting && cyc_q != WD_LIMIT) ? cyc_q + 32'd1 : cyc_q;
      halt_d   = halt_q | halt_hit;
      done_d   = (state_d == ST_DONE);
      to_d     = (state_d == ST_TIMEOUT);
      ovf_d    = ovf_q | drop;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         cnt_q    <= '0;
         cyc_q    <= '0;
         halt_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         cnt_q    <= cnt_d;
         cyc_q    <= cyc_d;
         halt_q   <= halt_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         to_q     <= to_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.bus_wdata_i;
   end

   assign bus.sig_valid_o = !empty;
   assign bus.sig_data_o  = empty ? '0 : mem_q[rd_ptr_q];
   assign sig_count_o     = cnt_q;
   assign halt_o          = halt_q;
   assign done_o          = done_q;
   assign overflow_o      = ovf_q;
   assign timeout_o       = to_q;

`ifdef SIG_CAPTURE_CRC_EN
   logic [31:0] crc_q, crc_d;

   function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] d);
      logic [31:0] c;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
         else              c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

   always_comb begin
      crc_d = push ? crc32_word(crc_q, bus.bus_wdata_i) : crc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) crc_q <= 32'hFFFFFFFF;
      else       crc_q <= crc_d;
   end

   assign crc_o = crc_q;
`else
   assign crc_o = '0;
`endif

endmodule

// File: tb/tb_sig_capture_unit.sv
// Scoreboard bench for sig_capture_unit: directed scenarios plus randomized phases
// checked against a queue-based behavioural model.
module tb_sig_capture_unit;
   localparam logic [31:0] SIG  = 32'h8E000000;
   localparam logic [31:0] HALT = 32'h8F000000;
   localparam int D = 16;
   localparam int T = 50;
   localparam int S_RUN = 0, S_DRAIN = 1, S_DONE = 2, S_TO = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [15:0] sig_count_o;
   logic halt_o, done_o, overflow_o, timeout_o;
   logic [31:0] crc_o;

   always #5 clk = ~clk;

   sig_capture_unit_if bus();

   sig_capture_unit #(
      .SIG_ADDR(SIG), .HALT_ADDR(HALT), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)
   ) u_dut (
      .clk(clk), .reset(reset), .bus(bus),
      .sig_count_o(sig_count_o), .halt_o(halt_o), .done_o(done_o),
      .overflow_o(overflow_o), .timeout_o(timeout_o), .crc_o(crc_o)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] m_fifo[$];
   int          m_state, m_cnt, m_cyc;
   bit          m_halt, m_ovf;
   logic [31:0] m_crc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // CRC as polynomial remainder: ((crc ^ word) * x^32) mod P
   function automatic logic [31:0] crc_ref(input logic [31:0] crc, input logic [31:0] w);
      logic [63:0] r;
      logic [63:0] p;
      r = {crc ^ w, 32'h0};
      for (int i = 63; i >= 32; i--) begin
         p = {31'h0, 33'h104C11DB7} << (i - 32);
         if (r[i]) r = r ^ p;
      end
      return r[31:0];
   endfunction

   task automatic model_clear();
      m_fifo.delete();
      m_state = S_RUN; m_cnt = 0; m_cyc = 0; m_halt = 0; m_ovf = 0;
`ifdef SIG_CAPTURE_CRC_EN
      m_crc = 32'hFFFFFFFF;
`else
      m_crc = 32'h0;
`endif
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.bus_wr_i = 1'b0; bus.bus_addr_i = '0; bus.bus_wdata_i = '0; bus.sig_ready_i = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      check("rst_valid", {31'h0, bus.sig_valid_o}, 32'h0);
      check("rst_flags", {28'h0, halt_o, done_o, overflow_o, timeout_o}, 32'h0);
      check("rst_count", {16'h0, sig_count_o}, 32'h0);
   endtask

   // One clock: apply inputs, predict the edge, advance the model after it.
   task automatic step(input bit wr, input logic [31:0] addr, input logic [31:0] data, input bit rdy);
      int sz, nstate;
      bit pop, acc, ovf_n, halt_n, counting;
      bus.bus_wr_i = wr; bus.bus_addr_i = addr; bus.bus_wdata_i = data; bus.sig_ready_i = rdy;
      sz = m_fifo.size();
      pop = rdy && (sz > 0);
      acc = 0; ovf_n = 0; halt_n = 0; nstate = m_state;
      counting = (m_state == S_RUN) || (m_state == S_DRAIN);
      if (m_state == S_RUN) begin
         if (wr && addr == SIG) begin
            if (sz < D || pop) acc = 1; else ovf_n = 1;
         end
         if (wr && addr == HALT) begin nstate = S_DRAIN; halt_n = 1; end
         else if (m_cyc + 1 == T) nstate = S_TO;
      end else if (m_state == S_DRAIN) begin
         if (sz == 0) nstate = S_DONE;
         else if (m_cyc + 1 == T) nstate = S_TO;
      end
      @(posedge clk); #1;
      if (acc) begin
         m_fifo.push_back(data);
         if (m_cnt < 16'hFFFF) m_cnt++;
`ifdef SIG_CAPTURE_CRC_EN
         m_crc = crc_ref(m_crc, data);
`endif
      end
      if (ovf_n) m_ovf = 1;
      if (halt_n) m_halt = 1;
      if (counting && m_cyc < T) m_cyc++;
      m_state = nstate;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, rdy);
   endtask

   // Monitor: pops the scoreboard whenever the DUT hands a word to the consumer.
   always @(negedge clk) begin
      logic [31:0] exp;
      if (!reset) begin
         check("valid", {31'h0, bus.sig_valid_o}, {31'h0, m_fifo.size() > 0});
         if (m_fifo.size() > 0) begin
            if (bus.sig_ready_i) begin
               exp = m_fifo.pop_front();
               check("pop_data", bus.sig_data_o, exp);
            end else
               check("head_data", bus.sig_data_o, m_fifo[0]);
         end else
            check("empty_data", bus.sig_data_o, 32'h0);
         check("count", {16'h0, sig_count_o}, 32'(m_cnt));
         check("halt", {31'h0, halt_o}, {31'h0, m_halt});
         check("done", {31'h0, done_o}, {31'h0, m_state == S_DONE});
         check("overflow", {31'h0, overflow_o}, {31'h0, m_ovf});
         check("timeout", {31'h0, timeout_o}, {31'h0, m_state == S_TO});
         check("crc", crc_o, m_crc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench did not terminate");
   end

   initial begin
      int n, k;
      logic [31:0] a;
      model_clear();

      // two words with stalled consumer, then drain in order
      do_reset();
      step(1, SIG, 32'h11111111, 0);
      step(1, SIG, 32'h22222222, 0);
      check("t1_valid", {31'h0, bus.sig_valid_o}, 32'h1);
      check("t1_head", bus.sig_data_o, 32'h11111111);
      check("t1_count", {16'h0, sig_count_o}, 32'd2);
      idle(3, 1);
      check("t1_drained", {31'h0, bus.sig_valid_o}, 32'h0);

      // 17 writes into a 16-deep FIFO, last one dropped
      do_reset();
      for (int i = 0; i < 17; i++) step(1, SIG, 32'hA0000000 + 32'(i), 0);
      check("t2_count", {16'h0, sig_count_o}, 32'd16);
      check("t2_ovf", {31'h0, overflow_o}, 32'h1);
      idle(18, 1);
      check("t2_empty", {31'h0, bus.sig_valid_o}, 32'h0);

      // full FIFO, 17th write coincides with a pop
      do_reset();
      for (int i = 0; i < 16; i++) step(1, SIG, 32'hB0000000 + 32'(i), 0);
      step(1, SIG, 32'hB0000010, 1);
      check("t3_ovf", {31'h0, overflow_o}, 32'h0);
      check("t3_count", {16'h0, sig_count_o}, 32'd17);
      idle(18, 1);

      // halt, drain, done, later signature write ignored
      do_reset();
      for (int i = 0; i < 3; i++) step(1, SIG, 32'hC0000000 + 32'(i), 0);
      step(1, HALT, 32'h0, 1);
      check("t4_halt", {31'h0, halt_o}, 32'h1);
      idle(3, 1);
      check("t4_done", {31'h0, done_o}, 32'h1);
      step(1, SIG, 32'hDEADBEEF, 1);
      idle(1, 1);
      check("t4_count", {16'h0, sig_count_o}, 32'd3);

      // watchdog expiry, writes ignored afterwards, reset clears it
      do_reset();
      idle(T - 1, 0);
      check("t5_pre", {31'h0, timeout_o}, 32'h0);
      idle(1, 0);
      check("t5_to", {31'h0, timeout_o}, 32'h1);
      check("t5_done", {31'h0, done_o}, 32'h0);
      step(1, SIG, 32'h12345678, 0);
      check("t5_ign", {16'h0, sig_count_o}, 32'd0);
      do_reset();

      // halt on the limit cycle wins over the watchdog
      idle(T - 1, 0);
      step(1, HALT, 32'h0, 0);
      idle(3, 0);
      check("t6_done", {31'h0, done_o}, 32'h1);
      check("t6_to", {31'h0, timeout_o}, 32'h0);

      // single zero word CRC
      do_reset();
      step(1, SIG, 32'h0, 0);
`ifdef SIG_CAPTURE_CRC_EN
      check("t7_crc", crc_o, 32'hC704DD7B);
`else
      check("t7_crc", crc_o, 32'h0);
`endif
      idle(2, 1);

      // randomized phases
      for (int p = 0; p < 30; p++) begin
         do_reset();
         n = $urandom_range(10, 70);
         for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 39);
            if (k < 20)       a = SIG;
            else if (k == 20) a = HALT;
            else              a = $urandom();
            step($urandom_range(0, 3) != 0, a, $urandom(), $urandom_range(0, 2) == 0);
         end
         idle(20, 1);
      end

      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
